// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the 4-entry, 8-bit-instruction pipeline CPU and its
// instruction-memory loader: geometry constants, opcode encodings, instruction
// field positions, the loader state enum and the loader output flags.
package cpu_pkg;

  // Instruction memory geometry
  localparam int IW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  // Opcode encodings (instruction bits [7:6])
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  // Instruction field slice positions
  localparam int OPC_HI = 7;
  localparam int OPC_LO = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 4;
  localparam int RS1_HI = 3;
  localparam int RS1_LO = 2;
  localparam int RS2_HI = 1;
  localparam int RS2_LO = 0;

  // Loader sequencing states
  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    FILLING,
    DONE,
    ERR
  } loader_state_t;

  // Flags the loader presents to the outside world; registered together
  // with the state so every flag is a clean flop output.
  typedef struct packed {
    logic in_ready;
    logic busy;
    logic done;
    logic err;
    logic cpu_rst;
  } loader_outs_t;

  // Output flags that belong to a given state. The FSM loads these into
  // its output register on the same edge it enters the state.
  function automatic loader_outs_t state_outs(input loader_state_t s);
    loader_outs_t o;
    o.in_ready = (s == LEN) || (s == DATA) || (s == CSUM);
    o.busy     = (s == LEN) || (s == DATA) || (s == CSUM) || (s == FILLING);
    o.done     = (s == DONE);
    o.err      = (s == ERR);
    o.cpu_rst  = (s != DONE);
    return o;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
// Bundles the loader's byte-stream handshake and the CPU fetch port.
//   in_valid / in_data / in_ready : framed byte stream into the loader
//   rd_addr / rd_data             : CPU fetch address and instruction
// master : the side that sends bytes and fetches instructions (source/CPU/bench)
// slave  : the loader itself
interface imem_loader_if #(
  parameter int IW = 8,
  parameter int AW = 2
);

  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data;

  modport master (
    output in_valid,
    output in_data,
    output rd_addr,
    input  in_ready,
    input  rd_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  rd_addr,
    output in_ready,
    output rd_data
  );

endinterface

// File: rtl/imem_loader_instr_ram.sv
// instr_ram
// DEPTH x IW instruction storage.
//   clk, rst : clock and synchronous active-high clear (all entries -> FILL)
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : combinational read port
module instr_ram #(
  parameter int             IW    = 8,
  parameter int             DEPTH = 4,
  parameter int             AW    = 2,
  parameter logic [IW-1:0]  FILL  = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  // Storage array: reset wipes every entry back to the fill value so a
  // half-loaded program never survives an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= FILL;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Instruction-memory writer and boot sequencer. Accepts a framed byte stream
// (count N, N instructions, XOR checksum), writes the instructions into the
// memory it owns, pads the rest with FILL and releases the CPU from reset
// only once a complete, checksum-valid program is in place.
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle pulse beginning a load (IDLE, DONE, ERR only)
//   bus      : byte stream (in_valid/in_data/in_ready) and fetch port
//              (rd_addr/rd_data, combinational)
//   cpu_rst  : CPU reset, low only in DONE
//   busy     : load in progress (LEN, DATA, CSUM, FILLING)
//   done     : program loaded and verified
//   err      : bad length or checksum; held until the next start or rst
import cpu_pkg::*;

module imem_loader #(
  parameter int            IW    = cpu_pkg::IW,
  parameter int            DEPTH = cpu_pkg::DEPTH,
  parameter int            AW    = cpu_pkg::AW,
  parameter logic [IW-1:0] FILL  = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  imem_loader_if.slave     bus,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [7:0]    DEPTH_B  = 8'(DEPTH);
  localparam logic [AW:0]   FULL_LEN = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  loader_state_t state;
  loader_outs_t  outs;
  logic [AW:0]   len;
  logic [AW-1:0] wr_ptr;
  logic [7:0]    acc;

  logic          xfer;
  logic          ram_we;
  logic [IW-1:0] ram_wdata;

  assign xfer = bus.in_valid && outs.in_ready;

  // Memory writes happen on every accepted instruction byte and on every
  // padding cycle; padding always writes FILL.
  assign ram_we    = ((state == DATA) && xfer) || (state == FILLING);
  assign ram_wdata = (state == FILLING) ? FILL : bus.in_data[IW-1:0];

  // Load sequencer. Each transition loads the destination state's flags
  // into the output register on the same edge, so all status outputs are
  // flop outputs that change exactly when the state does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      outs   <= state_outs(IDLE);
      len    <= '0;
      wr_ptr <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LEN;
            outs  <= state_outs(LEN);
          end
        end
        LEN: begin
          if (xfer) begin
            if ((bus.in_data == 8'h00) || (bus.in_data > DEPTH_B)) begin
              state <= ERR;
              outs  <= state_outs(ERR);
            end else begin
              len    <= bus.in_data[AW:0];
              acc    <= bus.in_data;
              wr_ptr <= '0;
              state  <= DATA;
              outs   <= state_outs(DATA);
            end
          end
        end
        DATA: begin
          // wr_ptr counts writes; the N-th write is the one where the
          // post-increment count equals N.
          if (xfer) begin
            acc    <= acc ^ bus.in_data;
            wr_ptr <= wr_ptr + PTR_ONE;
            if (({1'b0, wr_ptr} + LEN_ONE) == len) begin
              state <= CSUM;
              outs  <= state_outs(CSUM);
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            if (bus.in_data == acc) begin
              if (len == FULL_LEN) begin
                state <= DONE;
                outs  <= state_outs(DONE);
              end else begin
                state <= FILLING;
                outs  <= state_outs(FILLING);
              end
            end else begin
              state <= ERR;
              outs  <= state_outs(ERR);
            end
          end
        end
        FILLING: begin
          // wr_ptr already points just past the program; pad until it wraps.
          wr_ptr <= wr_ptr + PTR_ONE;
          if (wr_ptr == LAST_PTR) begin
            state <= DONE;
            outs  <= state_outs(DONE);
          end
        end
        DONE, ERR: begin
          if (start) begin
            state <= LEN;
            outs  <= state_outs(LEN);
          end
        end
        default: begin
          state <= IDLE;
          outs  <= state_outs(IDLE);
        end
      endcase
    end
  end

  instr_ram #(
    .IW    (IW),
    .DEPTH (DEPTH),
    .AW    (AW),
    .FILL  (FILL)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (ram_wdata),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data)
  );

  assign bus.in_ready = outs.in_ready;
  assign busy         = outs.busy;
  assign done         = outs.done;
  assign err          = outs.err;
  assign cpu_rst      = outs.cpu_rst;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed bench for imem_loader: drives framed programs through the byte
// stream and compares status flags and memory contents with hand-computed
// values. Inputs change and outputs are sampled on the falling clock edge.
module tb_imem_loader;
  import cpu_pkg::*;

  logic clk;
  logic rst;
  logic start;
  logic cpu_rst;
  logic busy;
  logic done;
  logic err;

  int tests_run;
  int tests_failed;

  imem_loader_if #(.IW(8), .AW(2)) bus ();

  imem_loader dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus.slave),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Offers one byte and holds it until the loader accepts it (bounded).
  task automatic applyStimulus(input logic [7:0] b);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) checkOutput("byte_accept_timeout", 32'(waited), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reads all four entries through the combinational fetch port.
  task automatic checkMem(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 2'(i);
      #1;
      checkOutput($sformatf("%s_mem%0d", tag, i), 32'(bus.rd_data), 32'(exp[i]));
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.rd_addr  = 2'd0;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_busy",     32'(busy),         32'd0);
    checkOutput("rst_done",     32'(done),         32'd0);
    checkOutput("rst_err",      32'(err),          32'd0);
    checkOutput("rst_cpu_rst",  32'(cpu_rst),      32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_no_ready", 32'(bus.in_ready), 32'd0);

    // Full program: 04 19 59 82 00, checksum 04^19^59^82^00 = C6.
    // Six accepted bytes after the start edge land in DONE on the 6th edge.
    pulseStart();
    checkOutput("full_busy_len", 32'(busy),    32'd1);
    checkOutput("full_cpu_rst",  32'(cpu_rst), 32'd1);
    applyStimulus(8'h04);
    applyStimulus(8'h19);
    applyStimulus(8'h59);
    applyStimulus(8'h82);
    applyStimulus(8'h00);
    checkOutput("full_pre_csum_done", 32'(done), 32'd0);
    applyStimulus(8'hC6);
    checkOutput("full_done",     32'(done),         32'd1);
    checkOutput("full_cpu_rst0", 32'(cpu_rst),      32'd0);
    checkOutput("full_busy0",    32'(busy),         32'd0);
    checkOutput("full_ready0",   32'(bus.in_ready), 32'd0);
    checkMem("full", 8'h19, 8'h59, 8'h82, 8'h00);

    // Short program: 02 19 59, checksum 42; two padding cycles overwrite entry 2.
    pulseStart();
    checkOutput("short_restart_cpu_rst", 32'(cpu_rst), 32'd1);
    applyStimulus(8'h02);
    applyStimulus(8'h19);
    applyStimulus(8'h59);
    applyStimulus(8'h42);
    checkOutput("short_fill1_busy",  32'(busy),         32'd1);
    checkOutput("short_fill1_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    checkOutput("short_fill2_done", 32'(done), 32'd0);
    @(negedge clk);
    checkOutput("short_done", 32'(done), 32'd1);
    checkMem("short", 8'h19, 8'h59, 8'h00, 8'h00);

    // Bad checksum: 01 82, checksum should be 83 but 00 is sent.
    pulseStart();
    applyStimulus(8'h01);
    applyStimulus(8'h82);
    applyStimulus(8'h00);
    checkOutput("badcs_err",     32'(err),          32'd1);
    checkOutput("badcs_cpu_rst", 32'(cpu_rst),      32'd1);
    checkOutput("badcs_ready",   32'(bus.in_ready), 32'd0);
    @(negedge clk);
    checkOutput("badcs_err_sticky", 32'(err), 32'd1);
    pulseStart();
    checkOutput("badcs_err_cleared", 32'(err),  32'd0);
    checkOutput("badcs_restart_busy", 32'(busy), 32'd1);

    // Bad length 00 (already in LEN from the restart above)
    applyStimulus(8'h00);
    checkOutput("len0_err",  32'(err),  32'd1);
    checkOutput("len0_busy", 32'(busy), 32'd0);
    checkMem("len0", 8'h82, 8'h59, 8'h00, 8'h00);

    // Bad length 05
    pulseStart();
    applyStimulus(8'h05);
    checkOutput("len5_err", 32'(err), 32'd1);
    checkMem("len5", 8'h82, 8'h59, 8'h00, 8'h00);

    // Backpressure: one bubble cycle before every byte of the full program
    pulseStart();
    begin
      logic [7:0] prog [6];
      prog[0] = 8'h04; prog[1] = 8'h19; prog[2] = 8'h59;
      prog[3] = 8'h82; prog[4] = 8'h00; prog[5] = 8'hC6;
      for (int i = 0; i < 6; i++) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
        applyStimulus(prog[i]);
      end
    end
    checkOutput("bp_done", 32'(done), 32'd1);
    checkOutput("bp_err",  32'(err),  32'd0);
    checkMem("bp", 8'h19, 8'h59, 8'h82, 8'h00);

    // Start pulsed during DATA is ignored: 03 A1 B2 C3, checksum D3, one pad
    pulseStart();
    applyStimulus(8'h03);
    applyStimulus(8'hA1);
    pulseStart();
    checkOutput("mid_start_busy", 32'(busy), 32'd1);
    applyStimulus(8'hB2);
    applyStimulus(8'hC3);
    applyStimulus(8'hD3);
    @(negedge clk);
    checkOutput("mid_start_done", 32'(done), 32'd1);
    checkOutput("mid_start_err",  32'(err),  32'd0);
    checkMem("mid_start", 8'hA1, 8'hB2, 8'hC3, 8'h00);

    // Abort: reset after two instruction bytes clears everything
    pulseStart();
    applyStimulus(8'h04);
    applyStimulus(8'h19);
    applyStimulus(8'h59);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy",    32'(busy),         32'd0);
    checkOutput("abort_done",    32'(done),         32'd0);
    checkOutput("abort_err",     32'(err),          32'd0);
    checkOutput("abort_cpu_rst", 32'(cpu_rst),      32'd1);
    checkOutput("abort_ready",   32'(bus.in_ready), 32'd0);
    checkMem("abort", 8'h00, 8'h00, 8'h00, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_idle_ready", 32'(bus.in_ready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
